// File: rtl/ceyloniac_regfile_debug_master.sv
`default_nettype none
// ============================================================================
// Module   : ceyloniac_regfile_debug_master
// Purpose  : Debug-host sequencer for the register file external access port.
//            It halts the core, performs a single read/write (or, with
//            CEYLONIAC_REGDBG_DUMP_EN defined, a full-file dump) and returns
//            one response per register touched.
// Config   : CEYLONIAC_REGDBG_DUMP_EN enables op 10 (dump all registers).
// Revision : 1.0 - initial release
// ============================================================================
module ceyloniac_regfile_debug_master #(
    parameter int REG_DATA_WIDTH = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      host_cmd_valid,
    output logic                      host_cmd_ready,
    input  logic [1:0]                host_cmd_op,
    input  logic [REG_ADDR_WIDTH-1:0] host_cmd_addr,
    input  logic [REG_DATA_WIDTH-1:0] host_cmd_data,
    output logic                      host_rsp_valid,
    input  logic                      host_rsp_ready,
    output logic [REG_ADDR_WIDTH-1:0] host_rsp_addr,
    output logic [REG_DATA_WIDTH-1:0] host_rsp_data,
    output logic                      host_rsp_error,
    output logic                      host_rsp_last,
    output logic                      core_halt_req,
    input  logic                      core_halted,
    output logic                      reg_external_control_enable,
    output logic [REG_ADDR_WIDTH-1:0] external_read_addr1,
    output logic [REG_ADDR_WIDTH-1:0] external_read_addr2,
    output logic [REG_ADDR_WIDTH-1:0] external_write_addr,
    output logic [REG_DATA_WIDTH-1:0] external_write_data,
    output logic                      external_write_enable,
    input  logic [REG_DATA_WIDTH-1:0] read_data1
);

    localparam logic [1:0] c_OP_READ  = 2'b00;
    localparam logic [1:0] c_OP_WRITE = 2'b01;
    localparam logic [1:0] c_OP_DUMP  = 2'b10;
    localparam logic [1:0] c_OP_RSVD  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HALT    = 3'd1,
        S_ACCESS  = 3'd2,
        S_CAPTURE = 3'd3,
        S_RESP    = 3'd4
    } state_t;

    state_t                    state_q, state_d;
    logic [1:0]                op_q, op_d;
    logic [REG_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [REG_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [REG_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                      err_q, err_d;
    logic                      w_reject;
    logic                      w_more;

    // Commands this build cannot execute are answered immediately with an error
`ifdef CEYLONIAC_REGDBG_DUMP_EN
    assign w_reject = (host_cmd_op == c_OP_RSVD);
    // Dump continues until the all-ones address; the counter never wraps
    assign w_more   = (op_q == c_OP_DUMP) && !err_q && (addr_q != '1);
`else
    assign w_reject = (host_cmd_op == c_OP_RSVD) || (host_cmd_op == c_OP_DUMP);
    assign w_more   = 1'b0;
`endif

    // State and command/response registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= c_OP_READ;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: command latch, halt wait, access, capture, response
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (host_cmd_valid) begin
                    op_d    = host_cmd_op;
                    wdata_d = host_cmd_data;
`ifdef CEYLONIAC_REGDBG_DUMP_EN
                    addr_d  = (host_cmd_op == c_OP_DUMP) ? '0 : host_cmd_addr;
`else
                    addr_d  = host_cmd_addr;
`endif
                    if (w_reject) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = S_RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = S_HALT;
                    end
                end
            end
            S_HALT: begin
                if (core_halted) begin
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                rdata_d = (op_q == c_OP_WRITE) ? wdata_q : read_data1;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (host_rsp_ready) begin
                    if (w_more) begin
                        addr_d  = addr_q + REG_ADDR_WIDTH'(1);
                        state_d = S_ACCESS;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are pure decodes of registered state; no input reaches an output
    assign host_cmd_ready              = (state_q == S_IDLE);
    assign host_rsp_valid              = (state_q == S_RESP);
    assign host_rsp_addr               = addr_q;
    assign host_rsp_data               = rdata_q;
    assign host_rsp_error              = (state_q == S_RESP) && err_q;
    assign host_rsp_last               = (state_q == S_RESP) && !w_more;
    assign core_halt_req               = (state_q == S_HALT) || (state_q == S_ACCESS) ||
                                         (state_q == S_CAPTURE) ||
                                         ((state_q == S_RESP) && !err_q);
    assign reg_external_control_enable = (state_q == S_ACCESS) || (state_q == S_CAPTURE);
    assign external_read_addr1         = addr_q;
    assign external_read_addr2         = '0;
    assign external_write_addr         = addr_q;
    assign external_write_data         = wdata_q;
    assign external_write_enable       = (state_q == S_ACCESS) && (op_q == c_OP_WRITE);

endmodule
`default_nettype wire
